sw_score_scanner: RTL and testbench

Read-side counterpart of the SW DP engine. After the engine has filled the score matrix, this block sweeps the matrix through the same (i, j, op, score) port, with op=read. It tracks the maximum signed cell score and its position, then delivers {score, row, column} on a valid/ready result interface. It sits between the score-matrix memory and the result/output path of the SW accelerator.

---
 rtl/sw_pkg.sv | 20 ++
 rtl/sw_rd_tag_pipe.sv | 41 ++++
 rtl/sw_score_scanner.sv | 136 +++++++++++++
 tb/tb_sw_score_scanner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and types for the Smith-Waterman accelerator blocks.
package sw_pkg;
  localparam int READ_MAX_D = 128;
  localparam int REF_MAX_D  = 128;
  localparam int SCORE_W_D  = 10;

  localparam int MATCH    = 2;
  localparam int MISMATCH = -1;
  localparam int GAP      = -1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;
endpackage

// File: rtl/sw_rd_tag_pipe.sv
// DEPTH-stage {valid, i, j} delay line that keeps matrix coordinates aligned
// with read data returning DEPTH cycles after the address.
module sw_rd_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 8,
  parameter int JW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [IW-1:0] i_i,
  input  logic [JW-1:0] i_j,
  output logic          o_valid,
  output logic [IW-1:0] o_i,
  output logic [JW-1:0] o_j
);
  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][IW-1:0] r_i;
  logic [DEPTH-1:0][JW-1:0] r_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_i[0]   <= i_i;
      r_j[0]   <= i_j;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_i[k]   <= r_i[k-1];
        r_j[k]   <= r_j[k-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_i     = r_i[DEPTH-1];
  assign o_j     = r_j[DEPTH-1];
endmodule

// File: rtl/sw_score_scanner.sv
// Sweeps the filled SW score matrix row-major and reports the maximum cell
// score with its 0-based position on a valid/ready result port.
module sw_score_scanner
  import sw_pkg::*;
#(
  parameter int READ_MAX = READ_MAX_D,
  parameter int REF_MAX  = REF_MAX_D,
  parameter int SCORE_W  = SCORE_W_D,
  parameter int RD_LAT   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [$clog2(READ_MAX):0]          i_read_len,
  input  logic [$clog2(REF_MAX):0]           i_ref_len,
  output logic [$clog2(READ_MAX):0]          o_mem_i,
  output logic [$clog2(REF_MAX):0]           o_mem_j,
  output logic                               o_mem_op,
  output logic [SCORE_W-1:0]                 o_mem_score,
  input  logic [SCORE_W-1:0]                 i_mem_score,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [SCORE_W-1:0]                 o_alignment_score,
  output logic [$clog2(READ_MAX)-1:0]        o_row,
  output logic [$clog2(REF_MAX)-1:0]         o_column
);
  localparam int RW  = $clog2(READ_MAX) + 1;
  localparam int CW  = $clog2(REF_MAX) + 1;
  localparam int RIW = $clog2(READ_MAX);
  localparam int CIW = $clog2(REF_MAX);
  localparam logic [RW-1:0] RMAX = RW'(READ_MAX);
  localparam logic [CW-1:0] CMAX = CW'(REF_MAX);

  scan_state_e               r_state;
  logic [RW-1:0]             r_ilen, r_mem_i;
  logic [CW-1:0]             r_jlen, r_mem_j;
  logic [2:0]                r_drain;
  logic signed [SCORE_W-1:0] r_max;
  logic [RIW-1:0]            r_row;
  logic [CIW-1:0]            r_col;

  logic          w_acc, w_tag_v, w_last_col, w_last, w_upd;
  logic [RW-1:0] w_rlen, w_tag_i, w_row;
  logic [CW-1:0] w_clen, w_tag_j, w_col;

  assign o_ready    = (r_state == S_IDLE);
  assign o_valid    = (r_state == S_DONE);
  assign w_acc      = i_valid && o_ready;
  assign w_rlen     = (i_read_len > RMAX) ? RMAX : i_read_len;
  assign w_clen     = (i_ref_len  > CMAX) ? CMAX : i_ref_len;
  assign w_last_col = (r_mem_j == r_jlen);
  assign w_last     = w_last_col && (r_mem_i == r_ilen);
  // Strictly greater keeps the first maximum in row-major order on ties.
  assign w_upd      = w_tag_v && ($signed(i_mem_score) > r_max);
  assign w_row      = w_tag_i - RW'(1);
  assign w_col      = w_tag_j - CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ilen  <= '0;
      r_jlen  <= '0;
      r_mem_i <= '0;
      r_mem_j <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_ilen <= w_rlen;
          r_jlen <= w_clen;
          // Zero-length jobs leave the address bus untouched.
          if (w_rlen == '0 || w_clen == '0) begin
            r_state <= S_DONE;
          end else begin
            r_mem_i <= RW'(1);
            r_mem_j <= CW'(1);
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_last) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end else if (w_last_col) begin
            r_mem_i <= r_mem_i + RW'(1);
            r_mem_j <= CW'(1);
          end else begin
            r_mem_j <= r_mem_j + CW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain == 3'(RD_LAT - 1)) r_state <= S_DONE;
          else                           r_drain <= r_drain + 3'd1;
        end
        S_DONE:  if (i_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_acc) begin
      r_max <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_upd) begin
      r_max <= $signed(i_mem_score);
      r_row <= w_row[RIW-1:0];
      r_col <= w_col[CIW-1:0];
    end
  end

  sw_rd_tag_pipe #(.DEPTH(RD_LAT), .IW(RW), .JW(CW)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_state == S_SCAN),
    .i_i     (r_mem_i),
    .i_j     (r_mem_j),
    .o_valid (w_tag_v),
    .o_i     (w_tag_i),
    .o_j     (w_tag_j)
  );

  assign o_mem_i           = r_mem_i;
  assign o_mem_j           = r_mem_j;
  assign o_mem_op          = OP_READ;
  assign o_mem_score       = '0;
  assign o_alignment_score = r_max;
  assign o_row             = r_row;
  assign o_column          = r_col;
endmodule

// File: tb/tb_sw_score_scanner.sv
// Scoreboard bench for sw_score_scanner: directed matrices, expected results
// queued at issue time and checked when o_valid rises.
module tb_sw_score_scanner;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, o_ready, i_ready, o_valid, o_mem_op;
  logic [7:0]        i_read_len, i_ref_len, o_mem_i, o_mem_j;
  logic [9:0]        o_mem_score;
  logic signed [9:0] i_mem_score, o_alignment_score;
  logic [6:0]        o_row, o_column;

  sw_score_scanner #(.READ_MAX(128), .REF_MAX(128), .SCORE_W(10), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_read_len(i_read_len), .i_ref_len(i_ref_len),
    .o_mem_i(o_mem_i), .o_mem_j(o_mem_j), .o_mem_op(o_mem_op), .o_mem_score(o_mem_score),
    .i_mem_score(i_mem_score), .o_valid(o_valid), .i_ready(i_ready),
    .o_alignment_score(o_alignment_score), .o_row(o_row), .o_column(o_column)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int r; int c; int lat; } exp_t;
  exp_t sb[$];

  int vecs = 0, miss = 0, cyc = 0, hs_cyc = 0, chg = 0;
  logic prev_v = 1'b0;
  logic [15:0] prev_addr = '0;
  logic signed [9:0] mem [0:128][0:128];
  logic signed [9:0] rdp [RD_LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_addr <= {o_mem_i, o_mem_j};
    if ({o_mem_i, o_mem_j} != prev_addr) chg <= chg + 1;
  end

  // Memory model: data for the address of cycle k is presented in cycle k+RD_LAT.
  always @(posedge clk) begin
    rdp[0] <= mem[o_mem_i][o_mem_j];
    for (int k = 1; k < RD_LAT; k++) rdp[k] <= rdp[k-1];
  end
  assign i_mem_score = rdp[RD_LAT-1];

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) prev_v <= 1'b0;
    else begin
      if (o_valid && !prev_v) begin
        if (sb.size() == 0) check("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("score", int'(o_alignment_score), e.s);
          check("row", int'(o_row), e.r);
          check("col", int'(o_column), e.c);
          check("latency", cyc - hs_cyc + 1, e.lat);
        end
      end
      prev_v <= o_valid;
    end
  end

  task automatic fill(input int v);
    for (int a = 0; a <= 128; a++)
      for (int b = 0; b <= 128; b++) mem[a][b] = 10'(v);
  endtask

  task automatic issue(input int rl, input int fl, input int es, input int er,
                       input int ec, input bit push);
    int w, n;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 100) begin @(negedge clk); w++; end
    if (!o_ready) check("ready_timeout", 0, 1);
    i_read_len = 8'(rl);
    i_ref_len  = 8'(fl);
    i_valid    = 1'b1;
    n = (rl > 128 ? 128 : rl) * (fl > 128 ? 128 : fl);
    if (push) sb.push_back('{es, er, ec, (n == 0) ? 1 : n + RD_LAT + 1});
    @(posedge clk);
    #1;
    hs_cyc  = cyc;
    i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 20000) begin @(negedge clk); w++; end
    if (sb.size() != 0) begin
      check("result_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int c0;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_read_len = '0; i_ref_len = '0;
    for (int k = 0; k < RD_LAT; k++) rdp[k] = '0;
    fill(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(o_ready), 1);
    check("rst_valid", int'(o_valid), 0);
    check("rst_score", int'(o_alignment_score), 0);
    check("rst_row", int'(o_row), 0);
    check("rst_col", int'(o_column), 0);
    check("rst_mem_i", int'(o_mem_i), 0);
    check("rst_mem_j", int'(o_mem_j), 0);
    check("mem_op", int'(o_mem_op), 0);

    fill(0); mem[1][1] = 3; mem[2][2] = 7; mem[2][3] = 5;
    issue(2, 3, 7, 1, 1, 1); wait_done();

    fill(1); mem[1][2] = 4; mem[2][1] = 4; mem[2][3] = -5;
    issue(2, 3, 4, 0, 1, 1); wait_done();

    fill(0);  issue(4, 4, 0, 0, 0, 1); wait_done();
    fill(-3); issue(4, 4, 0, 0, 0, 1); wait_done();

    c0 = chg;
    fill(5); issue(0, 5, 0, 0, 0, 1); wait_done();
    issue(3, 0, 0, 0, 0, 1); wait_done();
    check("zero_len_addr_changes", chg - c0, 0);

    fill(2); mem[1][128] = 9; mem[1][129] = 50; mem[2][5] = 60;
    c0 = chg;
    issue(1, 200, 9, 0, 127, 1); wait_done();
    check("clamp_reads", chg - c0, 128);
    check("clamp_last_j", int'(o_mem_j), 128);

    fill(0); mem[1][1] = 3; mem[2][2] = 7; mem[2][3] = 5;
    i_ready = 1'b0;
    issue(2, 3, 7, 1, 1, 1); wait_done();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", int'(o_valid), 1);
      check("bp_ready", int'(o_ready), 0);
      check("bp_score", int'(o_alignment_score), 7);
      check("bp_row", int'(o_row), 1);
      check("bp_col", int'(o_column), 1);
      @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", int'(o_valid), 0);
    @(negedge clk);
    check("bp_ready_back", int'(o_ready), 1);

    fill(100); mem[1][1] = 510; mem[128][128] = 511;
    issue(128, 128, 511, 127, 127, 1); wait_done();

    issue(128, 128, 0, 0, 0, 0);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_ready", int'(o_ready), 1);
    check("midrst_mem_i", int'(o_mem_i), 0);
    @(negedge clk);
    rst = 1'b0;
    fill(0); mem[1][1] = 3; mem[2][2] = 7; mem[2][3] = 5;
    issue(2, 3, 7, 1, 1, 1); wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
